// File: rtl/counter_run_controller.sv
// Run/pause/terminal-count sequencer that prescales clk into cnt_en pulses for an external N-bit up-counter.
// Latency: start -> RUN on the next edge; first cnt_en on the DIV-th RUN cycle; cnt_rst one cycle after clear.
// Backpressure: none; start/stop/clear are single-cycle requests acted on at the next edge.
// Optional macro CTRL_AUTORELOAD_EN: periodic mode, the counter reloads at limit and state stays RUN.
module counter_run_controller #(
  parameter int N   = 4,
  parameter int DIV = 50,
  parameter int PW  = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic [N-1:0] limit,
  input  logic [N-1:0] q_cnt,
  output logic         cnt_en,
  output logic         cnt_rst,
  output logic         running,
  output logic         done,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // Terminal prescaler value; DIV may equal 2^PW, so DIV-1 always fits in PW bits.
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  state_t        cur, nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          rst_nxt;
  logic          at_limit;
  logic          wrap;

  assign at_limit = (q_cnt == limit);
  assign wrap     = (presc == PMAX);

`ifdef CTRL_AUTORELOAD_EN
  logic done_pulse, done_nxt;
`endif

  // Next-state, prescaler and counter-reset request decode; clear outranks every state action.
  always_comb begin
    nxt       = cur;
    presc_nxt = presc;
    rst_nxt   = 1'b0;
`ifdef CTRL_AUTORELOAD_EN
    done_nxt  = 1'b0;
`endif
    if (clear) begin
      nxt       = S_IDLE;
      presc_nxt = '0;
      rst_nxt   = 1'b1;
    end else begin
      case (cur)
        S_IDLE: begin
          // stop outranks start, so a simultaneous pair leaves IDLE untouched
          if (start && !stop) begin
            nxt       = S_RUN;
            presc_nxt = '0;
          end
        end
        S_RUN: begin
          presc_nxt = wrap ? '0 : presc + PW'(1);
`ifdef CTRL_AUTORELOAD_EN
          // Reload only at the end of the limit's prescale period so every value gets a full period.
          if (at_limit && wrap) begin
            rst_nxt  = 1'b1;
            done_nxt = 1'b1;
          end
          if (stop) nxt = S_PAUSE;
`else
          // Reaching the limit beats any start/stop request in the same cycle.
          if (at_limit)  nxt = S_DONE;
          else if (stop) nxt = S_PAUSE;
`endif
        end
        S_PAUSE: begin
          // Prescaler is held so the partial period resumes where it left off.
          if (start && !stop) nxt = S_RUN;
        end
        default: begin
          // DONE is left only through clear or reset.
          nxt = cur;
        end
      endcase
    end
  end

  // State, prescaler and registered reset/done pulses; reset overrides all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= S_IDLE;
      presc      <= '0;
      cnt_rst    <= 1'b0;
`ifdef CTRL_AUTORELOAD_EN
      done_pulse <= 1'b0;
`endif
    end else begin
      cur        <= nxt;
      presc      <= presc_nxt;
      cnt_rst    <= rst_nxt;
`ifdef CTRL_AUTORELOAD_EN
      done_pulse <= done_nxt;
`endif
    end
  end

  // Enable is decoded only from registers and the counter feedback, so it cannot overrun limit.
  always_comb begin
    cnt_en  = (cur == S_RUN) && wrap && !at_limit;
    running = (cur == S_RUN);
    state   = cur;
`ifdef CTRL_AUTORELOAD_EN
    done    = done_pulse;
`else
    done    = (cur == S_DONE);
`endif
  end

endmodule

// File: tb/tb_counter_run_controller.sv
// Directed bench for counter_run_controller with N=4, DIV=4, PW=2 and a behavioural up-counter.
module tb_counter_run_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] limit;
  logic [3:0] q_cnt;
  logic       cnt_en;
  logic       cnt_rst;
  logic       running;
  logic       done;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  counter_run_controller #(.N(4), .DIV(4), .PW(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .limit   (limit),
    .q_cnt   (q_cnt),
    .cnt_en  (cnt_en),
    .cnt_rst (cnt_rst),
    .running (running),
    .done    (done),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External counter: synchronous reset from either system reset or the controller's pulse.
  always_ff @(posedge clk) begin
    if (reset || cnt_rst) q_cnt <= '0;
    else if (cnt_en)      q_cnt <= q_cnt + 4'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, time=%0t required=finish", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; limit = 4'd3;
    step();
    step();
    checks++;
    if ({state, cnt_en, running, done, cnt_rst} !== 6'b00_0000) begin
      errors++;
      $display("FAIL reset_outputs: got st=%b en=%b run=%b done=%b rst=%b required 00 0 0 0 0",
               state, cnt_en, running, done, cnt_rst);
    end
    reset = 1'b0;
    step();
    checks++;
    if (q_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_q: got %0d required 0", q_cnt);
    end
  endtask

  task automatic test_terminal_count();
    int pulses;
    limit = 4'd3;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      checks++;
      if (cnt_en !== (c % 4 == 0)) begin
        errors++;
        $display("FAIL term_cnt_en cycle %0d: got %b required %b", c, cnt_en, (c % 4 == 0));
      end
      step();
    end
    checks++;
    if ({q_cnt, state, done} !== {4'd3, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL term_at_limit: got q=%0d st=%b done=%b required q=3 st=01 done=0", q_cnt, state, done);
    end
    step();
    checks++;
    if ({state, done, running} !== {2'b11, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL term_done: got st=%b done=%b run=%b required 11 1 0", state, done, running);
    end
    pulses = 0;
    start = 1'b1;   // ignored in DONE
    for (int c = 0; c < 20; c++) begin
      if (cnt_en) pulses++;
      step();
      if (c == 0) start = 1'b0;
    end
    checks++;
    if (pulses != 0 || state !== 2'b11 || q_cnt !== 4'd3) begin
      errors++;
      $display("FAIL term_hold: got pulses=%0d st=%b q=%0d required 0 11 3", pulses, state, q_cnt);
    end
    do_clear();
  endtask

  task automatic test_pause_resume();
    limit = 4'd9;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    checks++;
    if ({state, q_cnt} !== {2'b10, 4'd1}) begin
      errors++;
      $display("FAIL pause_enter: got st=%b q=%0d required 10 1", state, q_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({state, q_cnt, cnt_en} !== {2'b10, 4'd1, 1'b0}) begin
        errors++;
        $display("FAIL pause_hold %0d: got st=%b q=%0d en=%b required 10 1 0", i, state, q_cnt, cnt_en);
      end
      stop = (i == 5);
      step();
    end
    stop = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if ({state, cnt_en} !== {2'b01, 1'b0}) begin
      errors++;
      $display("FAIL resume_first: got st=%b en=%b required 01 0", state, cnt_en);
    end
    step();
    checks++;
    if (cnt_en !== 1'b1) begin
      errors++;
      $display("FAIL resume_en: got %b required 1", cnt_en);
    end
    step();
    checks++;
    if (q_cnt !== 4'd2) begin
      errors++;
      $display("FAIL resume_q: got %0d required 2", q_cnt);
    end
    do_clear();
  endtask

  task automatic test_clear();
    limit = 4'd9;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 21; c++) step();
    checks++;
    if ({state, q_cnt} !== {2'b01, 4'd5}) begin
      errors++;
      $display("FAIL clear_pre: got st=%b q=%0d required 01 5", state, q_cnt);
    end
    clear = 1'b1; step(); clear = 1'b0;
    checks++;
    if ({state, cnt_rst, running} !== {2'b00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL clear_idle: got st=%b rst=%b run=%b required 00 1 0", state, cnt_rst, running);
    end
    step();
    checks++;
    if ({cnt_rst, q_cnt} !== {1'b0, 4'd0}) begin
      errors++;
      $display("FAIL clear_pulse: got rst=%b q=%0d required 0 0", cnt_rst, q_cnt);
    end
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (cnt_en !== (c == 4)) begin
        errors++;
        $display("FAIL clear_restart cycle %0d: got %b required %b", c, cnt_en, (c == 4));
      end
      step();
    end
    do_clear();
  endtask

  task automatic test_start_stop_together();
    limit = 4'd9;
    start = 1'b1; step(); start = 1'b0;
    start = 1'b1; stop = 1'b1; step();
    checks++;
    if (state !== 2'b10) begin
      errors++;
      $display("FAIL run_both: got st=%b required 10", state);
    end
    step();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (state !== 2'b10) begin
      errors++;
      $display("FAIL pause_both: got st=%b required 10", state);
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL pause_start: got st=%b required 01", state);
    end
    do_clear();
  endtask

  task automatic test_limit_zero();
    int pulses;
    limit = 4'd0;
    pulses = 0;
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if ({state, cnt_en} !== {2'b01, 1'b0}) begin
      errors++;
      $display("FAIL zero_run: got st=%b en=%b required 01 0", state, cnt_en);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      if (cnt_en) pulses++;
    end
    checks++;
    if ({state, done} !== {2'b11, 1'b1} || pulses != 0 || q_cnt !== 4'd0) begin
      errors++;
      $display("FAIL zero_done: got st=%b done=%b pulses=%0d q=%0d required 11 1 0 0", state, done, pulses, q_cnt);
    end
    do_clear();
  endtask

  task automatic test_autoreload();
    logic exp;
    limit = 4'd2;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      exp = (c == 13) || (c == 25);
      checks++;
      if ({cnt_rst, done, state} !== {exp, exp, 2'b01}) begin
        errors++;
        $display("FAIL auto cycle %0d: got rst=%b done=%b st=%b required %b %b 01", c, cnt_rst, done, state, exp, exp);
      end
      if (c == 12 || c == 14) begin
        checks++;
        if (q_cnt !== ((c == 12) ? 4'd2 : 4'd0)) begin
          errors++;
          $display("FAIL auto_q cycle %0d: got %0d required %0d", c, q_cnt, (c == 12) ? 2 : 0);
        end
      end
      step();
    end
    do_clear();
  endtask

  task automatic test_reset_midrun();
    limit = 4'd9;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 6; c++) step();
    checks++;
    if (q_cnt !== 4'd1) begin
      errors++;
      $display("FAIL midrun_pre: got q=%0d required 1", q_cnt);
    end
    reset = 1'b1; step();
    checks++;
    if ({state, cnt_en, cnt_rst, running} !== {2'b00, 3'b000}) begin
      errors++;
      $display("FAIL midrun_reset: got st=%b en=%b rst=%b run=%b required 00 0 0 0", state, cnt_en, cnt_rst, running);
    end
    start = 1'b1; step(); step();
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL reset_start: got st=%b required 00", state);
    end
    reset = 1'b0; start = 1'b0; step();
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got st=%b required 00", state);
    end
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({state, cnt_en} !== {2'b01, (c == 4)}) begin
        errors++;
        $display("FAIL reset_restart cycle %0d: got st=%b en=%b required 01 %b", c, state, cnt_en, (c == 4));
      end
      step();
    end
    do_clear();
  endtask

  initial begin
    test_reset();
`ifdef CTRL_AUTORELOAD_EN
    test_autoreload();
`else
    test_terminal_count();
    test_limit_zero();
`endif
    test_pause_resume();
    test_clear();
    test_start_stop_together();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
